can_tx_scheduler: RTL and testbench

Mailbox scheduler that sits in front of the CAN transmit container and decides which queued frame it sends next. It holds NUM_MB mailboxes (11-bit ID + 64-bit payload each) and always offers the pending frame with the numerically lowest ID, matching CAN bus priority. It drives the transmitter's address/data/send_data inputs and re-queues a frame that loses bus arbitration.

---
 rtl/can_pkg.sv | 16 +
 rtl/can_id_arbiter.sv | 35 +++
 rtl/can_tx_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_can_tx_scheduler.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/can_pkg.sv
// Shared CAN widths and the transmit scheduler state encoding.
// Pure declarations: no latency, no flow control.
package can_pkg;

   localparam int CAN_ID_W   = 11;
   localparam int CAN_DATA_W = 64;
   localparam int MB_IDX_W   = 3;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SELECT   = 2'd1,
      ST_REQUEST  = 2'd2,
      ST_WAIT_END = 2'd3
   } sched_state_e;

endpackage

// File: rtl/can_id_arbiter.sv
// Combinational lowest-ID finder over the pending mask; ties go to the lowest index.
// Zero latency; no backpressure (pure function of its inputs).
module can_id_arbiter
   import can_pkg::*;
#(
   parameter int NUM_MB = 4
) (
   input  logic [NUM_MB-1:0]          pending_i,
   input  logic [NUM_MB*CAN_ID_W-1:0] ids_i,
   output logic                       found_o,
   output logic [MB_IDX_W-1:0]        idx_o
);

   logic                found_d;
   logic [MB_IDX_W-1:0] idx_d;
   logic [CAN_ID_W-1:0] best_d;

   // Strict less-than keeps the earlier (lower) index on equal IDs.
   always_comb begin
      found_d = 1'b0;
      idx_d   = '0;
      best_d  = '1;
      for (int i = 0; i < NUM_MB; i++) begin
         if (pending_i[i] && (!found_d || (ids_i[i*CAN_ID_W +: CAN_ID_W] < best_d))) begin
            found_d = 1'b1;
            idx_d   = MB_IDX_W'(i);
            best_d  = ids_i[i*CAN_ID_W +: CAN_ID_W];
         end
      end
   end

   assign found_o = found_d;
   assign idx_o   = idx_d;

endmodule

// File: rtl/can_tx_scheduler.sv
// Mailbox scheduler feeding the CAN transmitter the lowest-ID pending frame; request 2 cycles after load.
// send_data is held until tx_busy is seen; lost frames re-arbitrate. Retry limit under CAN_TX_RETRY_LIMIT_EN.
module can_tx_scheduler
   import can_pkg::*;
#(
   parameter int NUM_MB    = 4,
   parameter int RETRY_MAX = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_MB-1:0]            mb_load,
   input  logic [NUM_MB*CAN_ID_W-1:0]   mb_id,
   input  logic [NUM_MB*CAN_DATA_W-1:0] mb_data,
   output logic [NUM_MB-1:0]            mb_pending,
   output logic                         load_err,
   output logic [CAN_ID_W-1:0]          address,
   output logic [CAN_DATA_W-1:0]        data,
   output logic                         send_data,
   input  logic                         tx_busy,
   input  logic                         tx_done,
   input  logic                         tx_lost,
   output logic                         sent_valid,
   output logic [MB_IDX_W-1:0]          sent_idx,
   output logic                         fail_valid
);

   sched_state_e          state_q, state_d;
   logic [CAN_ID_W-1:0]   id_q [NUM_MB];
   logic [CAN_DATA_W-1:0] pl_q [NUM_MB];
   logic [NUM_MB-1:0]     pending_q, pending_d;
   logic [MB_IDX_W-1:0]   cur_idx_q;
   logic [CAN_ID_W-1:0]   address_q;
   logic [CAN_DATA_W-1:0] data_q;
   logic                  send_q;
   logic                  load_err_q;
   logic                  sent_valid_q;
   logic [MB_IDX_W-1:0]   sent_idx_q;

   logic [NUM_MB*CAN_ID_W-1:0] ids_flat;
   logic                       arb_found;
   logic [MB_IDX_W-1:0]        arb_idx;
   logic [CAN_ID_W-1:0]        sel_id;
   logic [CAN_DATA_W-1:0]      sel_pl;
   logic [NUM_MB-1:0]          load_ok;
   logic                       load_rej;
   logic [MB_IDX_W-1:0]        flight_idx;
   logic                       done_evt, lost_evt, drop_evt;

   always_comb begin
      ids_flat = '0;
      for (int i = 0; i < NUM_MB; i++) ids_flat[i*CAN_ID_W +: CAN_ID_W] = id_q[i];
   end

   can_id_arbiter #(.NUM_MB(NUM_MB)) u_arb (
      .pending_i (pending_q),
      .ids_i     (ids_flat),
      .found_o   (arb_found),
      .idx_o     (arb_idx)
   );

   always_comb begin
      sel_id = '0;
      sel_pl = '0;
      for (int i = 0; i < NUM_MB; i++) begin
         if (arb_idx == MB_IDX_W'(i)) begin
            sel_id = id_q[i];
            sel_pl = pl_q[i];
         end
      end
   end

   // The winner is already committed during SELECT, so it is protected from reloads too.
   assign flight_idx = (state_q == ST_SELECT) ? arb_idx : cur_idx_q;

   always_comb begin
      load_ok  = '0;
      load_rej = 1'b0;
      for (int i = 0; i < NUM_MB; i++) begin
         if (mb_load[i]) begin
            if (state_q != ST_IDLE && flight_idx == MB_IDX_W'(i)) load_rej   = 1'b1;
            else                                                  load_ok[i] = 1'b1;
         end
      end
   end

   assign done_evt = (state_q == ST_WAIT_END) && tx_done;
   assign lost_evt = (state_q == ST_WAIT_END) && tx_lost && !tx_done;

`ifdef CAN_TX_RETRY_LIMIT_EN
   localparam logic [3:0] RETRY_LIM = 4'(RETRY_MAX);

   logic [3:0] lost_cnt_q [NUM_MB];
   logic [3:0] cur_cnt;
   logic       fail_valid_q;

   always_comb begin
      cur_cnt = '0;
      for (int i = 0; i < NUM_MB; i++) begin
         if (cur_idx_q == MB_IDX_W'(i)) cur_cnt = lost_cnt_q[i];
      end
   end

   assign drop_evt = lost_evt && ((cur_cnt + 4'd1) == RETRY_LIM);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fail_valid_q <= 1'b0;
         for (int i = 0; i < NUM_MB; i++) lost_cnt_q[i] <= '0;
      end else begin
         fail_valid_q <= drop_evt;
         for (int i = 0; i < NUM_MB; i++) begin
            if (load_ok[i] || (done_evt && cur_idx_q == MB_IDX_W'(i))) begin
               lost_cnt_q[i] <= '0;
            end else if (lost_evt && cur_idx_q == MB_IDX_W'(i)) begin
               lost_cnt_q[i] <= drop_evt ? 4'd0 : lost_cnt_q[i] + 4'd1;
            end
         end
      end
   end

   assign fail_valid = fail_valid_q;
`else
   assign drop_evt   = 1'b0;
   assign fail_valid = 1'b0;
`endif

   always_comb begin
      pending_d = pending_q | load_ok;
      for (int i = 0; i < NUM_MB; i++) begin
         if ((done_evt || drop_evt) && cur_idx_q == MB_IDX_W'(i)) pending_d[i] = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     if (|pending_q) state_d = ST_SELECT;
         ST_SELECT:   state_d = arb_found ? ST_REQUEST : ST_IDLE;
         ST_REQUEST:  if (tx_busy) state_d = ST_WAIT_END;
         ST_WAIT_END: if (tx_done || tx_lost) state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         pending_q    <= '0;
         cur_idx_q    <= '0;
         address_q    <= '0;
         data_q       <= '0;
         send_q       <= 1'b0;
         load_err_q   <= 1'b0;
         sent_valid_q <= 1'b0;
         sent_idx_q   <= '0;
         for (int i = 0; i < NUM_MB; i++) begin
            id_q[i] <= '0;
            pl_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         load_err_q   <= load_rej;
         sent_valid_q <= done_evt;
         if (done_evt || drop_evt) sent_idx_q <= cur_idx_q;
         if (state_q == ST_SELECT && arb_found) begin
            cur_idx_q <= arb_idx;
            address_q <= sel_id;
            data_q    <= sel_pl;
            send_q    <= 1'b1;
         end else if (state_q == ST_REQUEST && tx_busy) begin
            send_q    <= 1'b0;
         end
         for (int i = 0; i < NUM_MB; i++) begin
            if (load_ok[i]) begin
               id_q[i] <= mb_id[i*CAN_ID_W +: CAN_ID_W];
               pl_q[i] <= mb_data[i*CAN_DATA_W +: CAN_DATA_W];
            end
         end
      end
   end

   assign mb_pending = pending_q;
   assign load_err   = load_err_q;
   assign address    = address_q;
   assign data       = data_q;
   assign send_data  = send_q;
   assign sent_valid = sent_valid_q;
   assign sent_idx   = sent_idx_q;

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Directed bench for can_tx_scheduler: frames expected to complete are queued and checked on sent_valid.
module tb_can_tx_scheduler;
   import can_pkg::*;

   localparam int NUM_MB = 4;
`ifdef CAN_TX_RETRY_LIMIT_EN
   localparam bit RETRY_ON = 1'b1;
`else
   localparam bit RETRY_ON = 1'b0;
`endif

   logic                         clk = 1'b0;
   logic                         rst = 1'b1;
   logic [NUM_MB-1:0]            mb_load = '0;
   logic [NUM_MB*CAN_ID_W-1:0]   mb_id = '0;
   logic [NUM_MB*CAN_DATA_W-1:0] mb_data = '0;
   logic [NUM_MB-1:0]            mb_pending;
   logic                         load_err;
   logic [CAN_ID_W-1:0]          address;
   logic [CAN_DATA_W-1:0]        data;
   logic                         send_data;
   logic                         tx_busy = 1'b0;
   logic                         tx_done = 1'b0;
   logic                         tx_lost = 1'b0;
   logic                         sent_valid;
   logic [MB_IDX_W-1:0]          sent_idx;
   logic                         fail_valid;

   typedef struct {
      logic [MB_IDX_W-1:0]   idx;
      logic [CAN_ID_W-1:0]   id;
      logic [CAN_DATA_W-1:0] dat;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   can_tx_scheduler #(.NUM_MB(NUM_MB), .RETRY_MAX(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .mb_load    (mb_load),
      .mb_id      (mb_id),
      .mb_data    (mb_data),
      .mb_pending (mb_pending),
      .load_err   (load_err),
      .address    (address),
      .data       (data),
      .send_data  (send_data),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done),
      .tx_lost    (tx_lost),
      .sent_valid (sent_valid),
      .sent_idx   (sent_idx),
      .fail_valid (fail_valid)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_mb(input int idx, input logic [10:0] id, input logic [63:0] dat);
      mb_load[idx]              = 1'b1;
      mb_id[idx*CAN_ID_W +: CAN_ID_W]       = id;
      mb_data[idx*CAN_DATA_W +: CAN_DATA_W] = dat;
   endtask

   task automatic strobe();
      @(negedge clk);
      mb_load = '0;
   endtask

   task automatic push(input int idx, input logic [10:0] id, input logic [63:0] dat);
      exp_t e;
      e.idx = MB_IDX_W'(idx);
      e.id  = id;
      e.dat = dat;
      sb.push_back(e);
   endtask

   task automatic wait_req();
      for (int i = 0; i < 30 && !send_data; i++) @(negedge clk);
      chk("req_seen", 64'(send_data), 64'd1);
   endtask

   task automatic go_busy(input int dly);
      repeat (dly) @(negedge clk);
      chk("req_hold", 64'(send_data), 64'd1);
      tx_busy = 1'b1;
      @(negedge clk);
      chk("req_drop", 64'(send_data), 64'd0);
   endtask

   task automatic finish(input bit lose, input bit exp_fail, input int fail_idx);
      exp_t e;
      tx_busy = 1'b0;
      if (lose) tx_lost = 1'b1;
      else      tx_done = 1'b1;
      @(negedge clk);
      tx_lost = 1'b0;
      tx_done = 1'b0;
      chk("sent_valid", 64'(sent_valid), 64'(!lose));
      chk("fail_valid", 64'(fail_valid), 64'(exp_fail));
      if (fail_valid) chk("fail_idx", 64'(sent_idx), 64'(fail_idx));
      if (!lose) begin
         chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("sent_idx", 64'(sent_idx), 64'(e.idx));
            chk("sent_addr", 64'(address), 64'(e.id));
            chk("sent_data", data, e.dat);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_send", 64'(send_data), 64'd0);
      chk("rst_pending", 64'(mb_pending), 64'd0);
      chk("rst_addr", 64'(address), 64'd0);
      chk("rst_data", data, 64'd0);
      chk("rst_pulses", 64'({load_err, sent_valid, fail_valid}), 64'd0);
      chk("rst_idx", 64'(sent_idx), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Single frame with exact request latency
      set_mb(0, 11'h028, 64'hAAAA_AAAA_AAAA_AAAA);
      push(0, 11'h028, 64'hAAAA_AAAA_AAAA_AAAA);
      strobe();
      chk("t1_pending", 64'(mb_pending), 64'd1);
      chk("t1_send_n1", 64'(send_data), 64'd0);
      @(negedge clk);
      chk("t1_send_n2", 64'(send_data), 64'd0);
      @(negedge clk);
      chk("t1_send_up", 64'(send_data), 64'd1);
      chk("t1_addr", 64'(address), 64'h028);
      chk("t1_data", data, 64'hAAAA_AAAA_AAAA_AAAA);
      go_busy(3);
      @(negedge clk);
      finish(1'b0, 1'b0, 0);
      chk("t1_pending_clr", 64'(mb_pending), 64'd0);
      @(negedge clk);
      chk("t1_sent_pulse", 64'(sent_valid), 64'd0);

      // Priority ordering with an ID tie
      set_mb(1, 11'h300, 64'h1111_0000_0000_0001);
      set_mb(2, 11'h010, 64'h2222_0000_0000_0002);
      set_mb(3, 11'h010, 64'h3333_0000_0000_0003);
      push(2, 11'h010, 64'h2222_0000_0000_0002);
      push(3, 11'h010, 64'h3333_0000_0000_0003);
      push(1, 11'h300, 64'h1111_0000_0000_0001);
      strobe();
      for (int k = 0; k < 3; k++) begin
         wait_req();
         go_busy(1);
         finish(1'b0, 1'b0, 0);
      end

      // Lost arbitration lets a newly loaded higher-priority frame win
      set_mb(0, 11'h200, 64'h0000_0000_0000_0200);
      strobe();
      wait_req();
      go_busy(2);
      set_mb(1, 11'h100, 64'h0000_0000_0000_0100);
      strobe();
      chk("t3_load_ok", 64'(load_err), 64'd0);
      push(1, 11'h100, 64'h0000_0000_0000_0100);
      push(0, 11'h200, 64'h0000_0000_0000_0200);
      finish(1'b1, 1'b0, 0);
      chk("t3_still_pending", 64'(mb_pending[0]), 64'd1);
      wait_req();
      chk("t3_next_addr", 64'(address), 64'h100);
      go_busy(1);
      finish(1'b0, 1'b0, 0);
      wait_req();
      go_busy(1);
      finish(1'b0, 1'b0, 0);

      // Reload of the in-flight mailbox is rejected; another mailbox is accepted
      set_mb(0, 11'h055, 64'hF0F0_F0F0_F0F0_F0F0);
      push(0, 11'h055, 64'hF0F0_F0F0_F0F0_F0F0);
      strobe();
      wait_req();
      go_busy(1);
      set_mb(0, 11'h044, 64'h9999_9999_9999_9999);
      strobe();
      chk("t4_load_err", 64'(load_err), 64'd1);
      chk("t4_data_kept", data, 64'hF0F0_F0F0_F0F0_F0F0);
      set_mb(2, 11'h044, 64'h9999_9999_9999_9999);
      push(2, 11'h044, 64'h9999_9999_9999_9999);
      strobe();
      chk("t4_load_err_pulse", 64'(load_err), 64'd0);
      chk("t4_pend2", 64'(mb_pending[2]), 64'd1);
      finish(1'b0, 1'b0, 0);
      wait_req();
      go_busy(1);
      finish(1'b0, 1'b0, 0);

      // Retry limit (or unlimited retries when not compiled in)
      set_mb(1, 11'h0AA, 64'h0000_0000_0000_00AA);
      strobe();
      for (int k = 0; k < 3; k++) begin
         wait_req();
         chk("t5_addr", 64'(address), 64'h0AA);
         go_busy(1);
         finish(1'b1, RETRY_ON && (k == 2), 1);
      end
      chk("t5_pending", 64'(mb_pending[1]), 64'(!RETRY_ON));
      if (mb_pending[1]) begin
         push(1, 11'h0AA, 64'h0000_0000_0000_00AA);
         wait_req();
         go_busy(1);
         finish(1'b0, 1'b0, 0);
      end

      // Reset mid-frame
      set_mb(3, 11'h123, 64'h0000_0000_0000_0123);
      strobe();
      wait_req();
      #2 rst = 1'b1;
      #1;
      chk("t6_send_rst", 64'(send_data), 64'd0);
      chk("t6_pend_rst", 64'(mb_pending), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("t6_idle_send", 64'(send_data), 64'd0);
      chk("t6_idle_pend", 64'(mb_pending), 64'd0);
      chk("t6_idle_sent", 64'(sent_valid), 64'd0);

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
